// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder and the core top level.
// Optional DMEM_PARITY_EN adds a per-word even-parity bit (see data_mem_responder).
package dmem_pkg;

    localparam int DMEM_ADDR_W = 7;
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_CNT_W  = 16;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        CLEAR = 2'd1,
        READY = 2'd2
    } dmem_state_e;

    // Decoded core access for the current edge.
    typedef struct packed {
        logic rd;
        logic wr;
    } dmem_acc_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x WIDTH storage with one synchronous write port and one registered read port.
module dmem_array #(
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 1 << ADDR_W,
    parameter int WIDTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage itself is not reset; the responder clears it word by word after reset.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed SRAM responder for the core data-memory port: post-reset clear, load/store, access counters.
// Define DMEM_PARITY_EN to add per-word parity with par_inject / parity_err.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int                ADDR_W   = DMEM_ADDR_W,
    parameter int                DATA_W   = DMEM_DATA_W,
    parameter int                DEPTH    = 1 << ADDR_W,
    parameter int                CNT_W    = DMEM_CNT_W,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              CEN,
    input  logic              WEN,
    input  logic              OEN,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] Data2Mem,
`ifdef DMEM_PARITY_EN
    input  logic              par_inject,
    output logic              parity_err,
`endif
    output logic [DATA_W-1:0] ReadDataMem,
    output logic              mem_ready,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt
);

`ifdef DMEM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int MEM_W = DATA_W + PAR_W;

    dmem_state_e       state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q;
    logic              clr_we;
    logic              clr_last;
    dmem_acc_t         acc;

    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [MEM_W-1:0]  arr_wdata;
    logic [MEM_W-1:0]  clr_word;
    logic [MEM_W-1:0]  core_word;
    logic [MEM_W-1:0]  rword;

    assign clr_last = (clr_addr_q == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            clr_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (clr_we)
                clr_addr_q <= clr_addr_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        clr_we  = 1'b0;
        case (state_q)
            INIT:  state_d = CLEAR;
            CLEAR: begin
                clr_we = 1'b1;
                if (clr_last)
                    state_d = READY;
            end
            READY: state_d = READY;
            default: state_d = INIT;
        endcase
    end

    assign mem_ready = (state_q == READY);

    // Core accesses only count once the clear has finished.
    always_comb begin
        acc    = '0;
        acc.rd = mem_ready & ~CEN &  WEN;
        acc.wr = mem_ready & ~CEN & ~WEN;
    end

`ifdef DMEM_PARITY_EN
    assign clr_word  = {^INIT_VAL, INIT_VAL};
    assign core_word = {(^Data2Mem) ^ par_inject, Data2Mem};
`else
    assign clr_word  = INIT_VAL;
    assign core_word = Data2Mem;
`endif

    assign arr_we    = clr_we | acc.wr;
    assign arr_waddr = clr_we ? clr_addr_q : A;
    assign arr_wdata = clr_we ? clr_word : core_word;

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .WIDTH  (MEM_W)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (acc.rd),
        .raddr (A),
        .rdata (rword)
    );

    assign ReadDataMem = OEN ? '0 : rword[DATA_W-1:0];

`ifdef DMEM_PARITY_EN
    // vld_pipe[1] marks the cycle right after a serviced read, so the error pulses once with its data.
    logic [1:0] vld_pipe;
    assign vld_pipe[0] = acc.rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_pipe[1] <= 1'b0;
        else
            vld_pipe[1] <= vld_pipe[0];
    end

    assign parity_err = vld_pipe[1] & (^rword);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (acc.rd && (rd_cnt != '1))
                rd_cnt <= rd_cnt + 1'b1;
            if (acc.wr && (wr_cnt != '1))
                wr_cnt <= wr_cnt + 1'b1;
        end
    end

endmodule
